// File: rtl/writeback_queue_if.sv
// Handshake and register-file port bundle for writeback_queue.
// master = producer/consumer side, slave = the queue itself.
interface writeback_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              Ld_Valid;
  logic              Ld_Ready;
  logic [ADDR_W-1:0] Ld_Addr;
  logic [DATA_W-1:0] Ld_Data;

  logic              Alu_Valid;
  logic              Alu_Ready;
  logic [ADDR_W-1:0] Alu_Addr;
  logic [DATA_W-1:0] Alu_Data;

  logic              Stall;

  logic              WE;
  logic [ADDR_W-1:0] Addr_In;
  logic [DATA_W-1:0] Data_In;
  logic [CNT_W-1:0]  Count;

  logic [ADDR_W-1:0] Addr_Out_A;
  logic [ADDR_W-1:0] Addr_Out_B;
  logic [DATA_W-1:0] Rf_Data_A;
  logic [DATA_W-1:0] Rf_Data_B;
  logic [DATA_W-1:0] Data_Out_A;
  logic [DATA_W-1:0] Data_Out_B;

  modport slave (
    input  Ld_Valid, Ld_Addr, Ld_Data,
    input  Alu_Valid, Alu_Addr, Alu_Data,
    input  Stall,
    input  Addr_Out_A, Addr_Out_B, Rf_Data_A, Rf_Data_B,
    output Ld_Ready, Alu_Ready,
    output WE, Addr_In, Data_In, Count,
    output Data_Out_A, Data_Out_B
  );

  modport master (
    output Ld_Valid, Ld_Addr, Ld_Data,
    output Alu_Valid, Alu_Addr, Alu_Data,
    output Stall,
    output Addr_Out_A, Addr_Out_B, Rf_Data_A, Rf_Data_B,
    input  Ld_Ready, Alu_Ready,
    input  WE, Addr_In, Data_In, Count,
    input  Data_Out_A, Data_Out_B
  );
endinterface

// File: rtl/writeback_queue.sv
// Circular write-back FIFO merging load and ALU results into one register-file write port.
// Optional read-port forwarding from queued entries is enabled by defining WB_FORWARD_EN.
module writeback_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              ld_fire;
  logic              alu_fire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  // Ready is derived from registered occupancy, so a pop while full frees a slot only next cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign ld_fire   = bus.Ld_Valid && !full;
  assign alu_fire  = bus.Alu_Valid && !full && !bus.Ld_Valid;
  assign push      = ld_fire || alu_fire;
  assign pop       = !empty && !bus.Stall;
  assign push_addr = ld_fire ? bus.Ld_Addr : bus.Alu_Addr;
  assign push_data = ld_fire ? bus.Ld_Data : bus.Alu_Data;

  assign bus.Ld_Ready  = !full;
  assign bus.Alu_Ready = !full && !bus.Ld_Valid;
  assign bus.WE        = pop;
  assign bus.Addr_In   = addr_mem[rd_ptr];
  assign bus.Data_In   = data_mem[rd_ptr];
  assign bus.Count     = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0]  fwd_idx;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_a   = bus.Rf_Data_A;
    fwd_b   = bus.Rf_Data_B;
    fwd_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (addr_mem[fwd_idx] == bus.Addr_Out_A) fwd_a = data_mem[fwd_idx];
        if (addr_mem[fwd_idx] == bus.Addr_Out_B) fwd_b = data_mem[fwd_idx];
      end
    end
  end

  assign bus.Data_Out_A = fwd_a;
  assign bus.Data_Out_B = fwd_b;
`else
  logic unused_read_addr;
  assign unused_read_addr = &{1'b0, bus.Addr_Out_A, bus.Addr_Out_B};

  assign bus.Data_Out_A = bus.Rf_Data_A;
  assign bus.Data_Out_B = bus.Rf_Data_B;
`endif

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter ADDR_W, 8, register address width; SHALL match the register file's write and read address ports.
REQ-002 Parameter DATA_W, 16, register data width.
REQ-003 Parameter DEPTH, 4, queue entries; SHALL be a power of two, minimum 2.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Ld_Valid / Ld_Ready / Ld_Addr / Ld_Data  in / out / ADDR_W / DATA_W  load-result write request.
REQ-007 Alu_Valid / Alu_Ready / Alu_Addr / Alu_Data  in / out / ADDR_W / DATA_W  ALU-result write request.
REQ-008 Stall  in  1  downstream hold; no drain while high.
REQ-009 WE / Addr_In / Data_In  out / out / out  1 / ADDR_W / DATA_W  register-file write port.
REQ-010 Count  out  log2(DEPTH)+1  current occupancy.
REQ-011 Addr_Out_A, Addr_Out_B  in  ADDR_W  register-file read addresses, also driven to the register file.
REQ-012 Rf_Data_A, Rf_Data_B  in  DATA_W  raw register-file read data.
REQ-013 Data_Out_A, Data_Out_B  out  DATA_W  read data as seen by consumers.

Function
REQ-014 Storage SHALL be a circular FIFO of DEPTH {addr,data} entries with write pointer, read pointer and occupancy count.
REQ-015 At most one enqueue per cycle; Ld SHALL have fixed priority over Alu.
REQ-016 Ld_Ready SHALL equal (Count != DEPTH); Alu_Ready SHALL equal (Count != DEPTH) AND NOT Ld_Valid.
REQ-017 Transfer occurs at the rising edge when Valid and Ready are both high; data is captured at that edge.
REQ-018 WE SHALL be combinational: (Count != 0) AND NOT Stall; Addr_In/Data_In SHALL present the head entry; when WE is low, Addr_In and Data_In hold the head value (don't-care when empty, but SHALL NOT be X after reset).
REQ-019 Pop SHALL occur at the edge where WE is high; an entry enqueued at edge N SHALL be written to the register file at edge N+1 at the earliest (1-cycle latency).
REQ-020 Simultaneous push and pop SHALL leave Count unchanged; a push when empty and a pop in the same cycle is impossible, because WE is low when empty.
REQ-021 Full: Ready is low, and a pop in that cycle SHALL NOT raise Ready until the following cycle (no full-bypass).
REQ-022 Pointers SHALL wrap modulo DEPTH; Count SHALL never exceed DEPTH or underflow.
REQ-023 Entries to the same address SHALL drain in enqueue order; no merging or coalescing.

Reset
REQ-024 While rst_n is low: pointers = 0, Count = 0, WE = 0, Addr_In = 0, Data_In = 0, both Ready outputs = 1, and all entries invalidated.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries immediately, with no further register-file writes.
REQ-026 The first enqueue SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro WB_FORWARD_EN, when defined: Data_Out_A SHALL be the data of the youngest queued entry whose addr equals Addr_Out_A, including the head being written this cycle, else Rf_Data_A; Data_Out_B likewise; the path is purely combinational.
REQ-028 Without WB_FORWARD_EN: the ports SHALL remain, Data_Out_A = Rf_Data_A and Data_Out_B = Rf_Data_B, and no comparators are synthesized.

Verification
REQ-029 Reset, then Ld 10<-4 with Stall = 0 -> next cycle WE = 1, Addr_In = 10, Data_In = 4; the following cycle Count = 0 and WE = 0.
REQ-030 Ld_Valid and Alu_Valid both high, Ld 11<-5 and Alu 12<-6 -> Ld accepted and Alu_Ready = 0; Alu accepted the next cycle; writes drain in order 11 then 12.
REQ-031 Stall = 1 and five enqueues attempted -> Count = 4 and Ready = 0 on the fifth; release Stall -> four WE pulses in FIFO order, with pointer wrap exercised over 2 passes.
REQ-032 WB_FORWARD_EN defined: Stall = 1, enqueue 14<-8 then 14<-9, Addr_Out_A = 14, Rf_Data_A = 0 -> Data_Out_A = 9; without the macro -> Data_Out_A = 0.
REQ-033 3 entries queued, rst_n pulsed low mid-cycle -> WE drops to 0 immediately, Count = 0, and no write occurs after release.
